uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin controller that shares one UART transmitter (8N1, level-held data-valid, no done output) among N_REQ byte requesters.
- Accepts one byte per valid/ready handshake and holds the transmitter's data-valid and data stable for exactly one frame.
- Inserts an inter-frame gap, then re-arbitrates.
- Sits between the command/telemetry byte sources and the UART sender.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 87, transmitter bit-period setting; each bit occupies CLKS_PER_BIT+1 clocks.
- GAP_CLKS, 1, clocks of o_tx_dv low between frames (>=1).
- Derived localparam FRAME_CLKS = 10*(CLKS_PER_BIT+1).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  N_REQ  per-requester byte-valid; held until accepted.
- i_req_data  in  8*N_REQ  requester k byte at [8k+7:8k].
- o_req_ready  out  N_REQ  one-hot accept; transfer when valid&ready.
- o_tx_dv  out  1  to transmitter data-valid.
- o_tx_data  out  8  to transmitter data, registered.
- o_grant_id  out  clog2(N_REQ)  index of requester owning current/last frame.
- o_busy  out  1  high in any state except IDLE.
- o_frame_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (async assert): o_tx_dv=0, o_tx_data=0, o_req_ready=0, o_grant_id=0, o_frame_done=0, rr pointer=0, state=FLUSH, counter=0.
- States: FLUSH, IDLE, SEND, GAP.
- FLUSH:
  - o_tx_dv=0 for FRAME_CLKS cycles after reset release, letting any in-flight transmitter frame drain.
  - Then IDLE. o_busy=1.
- IDLE:
  - If no valid: stay.
  - Otherwise the winner is the first k with i_req_valid[k]=1, searching k = ptr, ptr+1, … mod N_REQ.
  - o_req_ready[winner]=1 combinationally in this cycle only.
  - On the clock edge: o_tx_data <= winner's byte, o_grant_id <= winner, ptr <= (winner+1) mod N_REQ, counter cleared, state <= SEND.
  - o_req_ready is never asserted outside IDLE, and never more than one bit.
- SEND:
  - o_tx_dv=1 for exactly FRAME_CLKS consecutive cycles, the first being the cycle after acceptance.
  - o_tx_data constant throughout.
  - On the last SEND cycle's edge: state <= GAP, o_frame_done pulses high in the first GAP cycle.
- GAP:
  - o_tx_dv=0 for GAP_CLKS cycles, then IDLE.
  - Requests arriving during SEND/GAP wait; they are evaluated in the first IDLE cycle.
- Latency: acceptance to o_tx_dv rise is 1 cycle. Back-to-back accept-to-accept spacing is FRAME_CLKS+GAP_CLKS+1 cycles minimum.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0; no requester waits more than N_REQ-1 frames.
- Simultaneous events:
  - Valid dropping in the same cycle as ready is treated as accepted (valid was sampled).
  - Valid dropping before ready is legal; no transfer occurs.
  - The pointer skips non-valid requesters without stalling.
- Counter width clog2(FRAME_CLKS+1); compares are exact, and the counter does not wrap within a frame.
- Reset mid-SEND: o_tx_dv drops immediately (async) and the frame is lost. After release, FLUSH runs a full FRAME_CLKS before any new grant; o_frame_done is not pulsed for the aborted frame.
- o_tx_dv, o_tx_data, o_grant_id, o_frame_done are registered. o_req_ready and o_busy may be combinational from state/valid.

Test Plan:
- Bench parameters: CLKS_PER_BIT=3 (FRAME_CLKS=40), GAP_CLKS=1, N_REQ=4; transmitter model attached.
- Reset release, no requests: o_tx_dv=0 for 40 cycles (FLUSH), then IDLE with o_busy=0; no ready pulses.
- Single request req1=0xA5 in IDLE: o_req_ready=4'b0010 for one cycle. Next cycle o_tx_dv=1 with o_tx_data=0xA5 for exactly 40 cycles. o_frame_done pulses once. Serial line shows start, 1,0,1,0,0,1,0,1, stop, each 4 clocks.
- All four requesters valid continuously (bytes 0x10,0x21,0x32,0x43): grants in order 0,1,2,3,0. Accept-to-accept spacing exactly 42 cycles. o_grant_id tracks each frame.
- Requests from 2 and 0 while ptr=1: 2 is granted first, then 0. Ptr becomes 3 after the first grant and 1 after the second.
- Request from 3 arriving mid-SEND: o_req_ready stays 0 until the first IDLE cycle after the 1-cycle GAP, then grant 3.
- Reset asserted at SEND cycle 20: o_tx_dv=0 in the same cycle. After release, 40 FLUSH cycles pass before the next ready. No o_frame_done for the aborted frame.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter among N_REQ byte sources.
// Each accepted byte holds o_tx_dv/o_tx_data for exactly one frame, followed by a gap.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 87,
    parameter int GAP_CLKS     = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [8*N_REQ-1:0]       i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_dv,
    output logic [7:0]               o_tx_data,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy,
    output logic                     o_frame_done
);
    localparam int FRAME_CLKS = 10 * (CLKS_PER_BIT + 1);
    localparam int ID_W       = $clog2(N_REQ);
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_SEND, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              frame_done_q, frame_done_d;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     idx;

    // Rotating priority search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!found && i_req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        tx_dv_d      = 1'b0;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        frame_done_d = 1'b0;
        o_req_ready  = '0;
        case (state_q)
            S_FLUSH: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (found) begin
                    o_req_ready[winner] = 1'b1;
                    tx_data_d = i_req_data[{winner, 3'b000} +: 8];
                    grant_d   = winner;
                    ptr_d     = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    cnt_d     = '0;
                    tx_dv_d   = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // tx_dv_d tracks the state the register will hold next cycle.
                if (cnt_q == FRAME_LAST) begin
                    state_d      = S_GAP;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    tx_dv_d = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_FLUSH;
            cnt_q        <= '0;
            ptr_q        <= '0;
            tx_dv_q      <= 1'b0;
            tx_data_q    <= '0;
            grant_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            tx_dv_q      <= tx_dv_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_tx_dv      = tx_dv_q;
    assign o_tx_data    = tx_data_q;
    assign o_grant_id   = grant_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-accurate reference model, attached UART transmitter
// model with a serial receiver, directed scenarios and randomized request traffic.
module tb_uart_tx_arbiter;
    localparam int N       = 4;
    localparam int CPB     = 3;
    localparam int GAP     = 1;
    localparam int FRAME   = 10 * (CPB + 1);
    localparam int SPACING = FRAME + GAP + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  o_req_ready;
    logic          o_tx_dv;
    logic [7:0]    o_tx_data;
    logic [1:0]    o_grant_id;
    logic          o_busy;
    logic          o_frame_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_data(req_data),
        .o_req_ready(o_req_ready), .o_tx_dv(o_tx_dv), .o_tx_data(o_tx_data),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    // Transmitter model: latches on dv when idle, sends start, 8 data LSB-first, stop.
    logic       tx_on = 1'b0;
    int         tick = 0;
    logic [9:0] tx_frame = '1;
    logic       line;
    always @(posedge clk) begin
        if (tx_on) begin
            if (tick == FRAME - 1) tx_on <= 1'b0;
            tick <= tick + 1;
        end else if (o_tx_dv) begin
            tx_on    <= 1'b1;
            tick     <= 0;
            tx_frame <= {1'b1, o_tx_data, 1'b0};
        end
    end
    assign line = tx_on ? tx_frame[tick / (CPB + 1)] : 1'b1;

    int n_total = 0;
    int n_bad   = 0;
    int cyc, free_at, acc_at, ptr, cur_gid;
    logic [7:0] cur_data;
    logic [7:0] exp_q[$];
    int obs_id[$];
    int obs_cyc[$];
    bit refill = 0;
    bit rand_mode = 0;
    bit rx_on = 0;
    int rcnt = 0;
    logic [9:0] rx_bits = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic model_init();
        cyc = 0; free_at = FRAME; acc_at = -1000; ptr = 0; cur_gid = 0; cur_data = 8'h00;
    endtask

    // Serial receiver, sampled mid-bit on falling clock edges.
    task automatic rx_sample();
        if (!rx_on) begin
            if (line == 1'b0) begin rx_on = 1; rcnt = 0; end
        end else begin
            rcnt++;
        end
        if (rx_on && (rcnt % (CPB + 1)) == 2) begin
            rx_bits[rcnt / (CPB + 1)] = line;
            if (rcnt / (CPB + 1) == 9) begin
                rx_on = 0;
                chk("rx_start", rx_bits[0], 0);
                chk("rx_stop", rx_bits[9], 1);
                if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
                else chk("rx_byte", rx_bits[8:1], exp_q.pop_front());
            end
        end
    endtask

    task automatic step();
        int w;
        int oid;
        logic [N-1:0] er;
        logic [N-1:0] clr;
        @(negedge clk);
        w  = (cyc >= free_at) ? pick(valid, ptr) : -1;
        er = (w >= 0) ? N'(1 << w) : '0;
        chk("ready", o_req_ready, er);
        chk("busy", o_busy, cyc < free_at);
        chk("tx_dv", o_tx_dv, (cyc > acc_at) && (cyc <= acc_at + FRAME));
        chk("frame_done", o_frame_done, cyc == acc_at + FRAME + 1);
        chk("tx_data", o_tx_data, cur_data);
        chk("grant_id", o_grant_id, cur_gid);
        oid = -1;
        for (int k = 0; k < N; k++) if (o_req_ready[k] && valid[k]) oid = k;
        if (oid >= 0) begin obs_id.push_back(oid); obs_cyc.push_back(cyc); end
        clr = '0;
        if (w >= 0) begin
            acc_at   = cyc;
            free_at  = cyc + SPACING;
            ptr      = (w + 1) % N;
            cur_data = req_data[8*w +: 8];
            cur_gid  = w;
            exp_q.push_back(req_data[8*w +: 8]);
            clr[w]   = 1'b1;
        end
        rx_sample();
        @(posedge clk);
        #1;
        cyc++;
        if (!refill) valid = valid & ~clr;
        if (rand_mode) begin
            for (int k = 0; k < N; k++) begin
                if (!valid[k]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        valid[k] = 1'b1;
                        req_data[8*k +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = '0; refill = 0; rand_mode = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx_dv", o_tx_dv, 0);
            chk("rst_tx_data", o_tx_data, 0);
            chk("rst_ready", o_req_ready, 0);
            chk("rst_grant", o_grant_id, 0);
            chk("rst_frame_done", o_frame_done, 0);
            chk("rst_busy", o_busy, 1);
            rx_sample();
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        model_init();
    endtask

    task automatic wait_acc(input int n, input int maxc);
        int lim;
        lim = 0;
        while (obs_id.size() < n && lim < maxc) begin step(); lim++; end
        chk("accept_timeout", obs_id.size() >= n, 1);
    endtask

    task automatic clear_obs();
        obs_id.delete(); obs_cyc.delete();
    endtask

    initial begin
        model_init();
        do_reset();
        // Flush window and idle with no requests.
        repeat (45) step();
        chk("t1_no_ready", obs_id.size(), 0);

        // Single request from requester 1.
        req_data[15:8] = 8'hA5; valid[1] = 1'b1;
        wait_acc(1, 10);
        chk("t2_id", obs_id[0], 1);
        chk("t2_cyc", obs_cyc[0], 45);
        repeat (50) step();
        chk("t2_rx_drained", exp_q.size(), 0);

        // All four valid continuously: strict rotation and minimum spacing.
        do_reset(); clear_obs();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10}; valid = 4'hF; refill = 1;
        wait_acc(5, 5 * SPACING + 50);
        refill = 0; valid = '0;
        chk("t3_first", obs_cyc[0], FRAME);
        for (int i = 0; i < 5; i++) chk("t3_id", obs_id[i], i % N);
        for (int i = 1; i < 5; i++) chk("t3_spacing", obs_cyc[i] - obs_cyc[i-1], SPACING);
        repeat (SPACING) step();

        // Pointer at 1 with requests from 2 and 0.
        clear_obs();
        req_data[23:16] = 8'h62; req_data[7:0] = 8'h60; valid = 4'b0101;
        wait_acc(2, 2 * SPACING + 10);
        chk("t4_first", obs_id[0], 2);
        chk("t4_second", obs_id[1], 0);
        repeat (SPACING) step();

        // Request from 3 arriving mid-frame waits for the first idle cycle.
        clear_obs();
        req_data[15:8] = 8'h5A; valid[1] = 1'b1;
        wait_acc(1, 10);
        repeat (10) step();
        req_data[31:24] = 8'hC3; valid[3] = 1'b1;
        wait_acc(2, 2 * SPACING);
        chk("t5_id", obs_id[1], 3);
        chk("t5_wait", obs_cyc[1] - obs_cyc[0], SPACING);
        repeat (SPACING) step();

        // Reset asserted in the 20th send cycle.
        clear_obs();
        req_data[23:16] = 8'h77; valid[2] = 1'b1;
        wait_acc(1, 10);
        repeat (19) step();
        chk("t6_dv_before", o_tx_dv, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_abort_dv", o_tx_dv, 0);
        chk("t6_abort_fd", o_frame_done, 0);
        do_reset(); clear_obs();
        req_data[7:0] = 8'h3C; valid[0] = 1'b1;
        wait_acc(1, FRAME + 10);
        chk("t6_flush_len", obs_cyc[0], FRAME);
        chk("t6_id", obs_id[0], 0);
        repeat (50) step();

        // Randomized traffic with legal withdrawals.
        clear_obs();
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0; valid = '0;
        repeat (SPACING + 50) step();
        chk("final_drain", exp_q.size(), 0);
        chk("final_rx_idle", rx_on, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", n_total, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
